bnn_layer_seq: RTL and testbench

Parametrised binarised-neural-network layer: N_OUT neurons, each firing when the XNOR-popcount of an N_IN-bit input vector against its weight vector reaches a per-neuron threshold. Weights and thresholds load through a serial parameter chain that can be daisy-chained across layers. Inputs load in CHUNK-bit slices. Neurons are evaluated one per cycle by a small FSM, so a single popcount datapath serves all of them, and the results are published atomically with a done pulse. It is the next-generation single-layer core for the tiny BNN top level.

---
 rtl/bnn_layer_seq.sv | 133 +++++++++++++
 tb/tb_bnn_layer_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_seq.sv
// bnn_layer_seq: one binarised neural-network layer with N_OUT neurons that
// share a single XNOR-popcount datapath. Each neuron takes one clock cycle.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   setup           shifts the parameter chain; also clears x and aborts evaluation
//   param_in/out    serial parameter chain (out = chain MSB, for daisy-chaining layers)
//   x_chunk/x_sel/x_we  input vector load, one CHUNK-bit slice per write
//   start           evaluation request (ignored while busy or in setup)
//   busy            evaluation in progress (N_OUT cycles)
//   done            one-cycle pulse when y has just been updated
//   y               registered neuron outputs
module bnn_layer_seq #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int CHUNK = 4,
  parameter int THR_W = $clog2(N_IN+1),
  localparam int XSW  = ((N_IN/CHUNK) > 1) ? $clog2(N_IN/CHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             setup,
  input  logic             param_in,
  output logic             param_out,
  input  logic [CHUNK-1:0] x_chunk,
  input  logic [XSW-1:0]   x_sel,
  input  logic             x_we,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] y
);

  localparam int F   = N_IN + THR_W;
  localparam int P   = N_OUT * F;
  localparam int NSL = N_IN / CHUNK;
  localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic {S_IDLE, S_EVAL} state_t;

  state_t           r_state;
  logic [P-1:0]     r_chain;
  logic [N_IN-1:0]  r_x;
  logic [N_OUT-1:0] r_shadow;
  logic [N_OUT-1:0] r_y;
  logic [KW-1:0]    r_k;
  logic             r_busy;
  logic             r_done;

  // Per-neuron views of the chain: weights low, threshold above them.
  logic [N_IN-1:0]  w_wt [N_OUT];
  logic [THR_W-1:0] w_th [N_OUT];

  for (genvar j = 0; j < N_OUT; j++) begin : g_field
    assign w_wt[j] = r_chain[j*F +: N_IN];
    assign w_th[j] = r_chain[j*F+N_IN +: THR_W];
  end

  // Shared datapath for neuron r_k. Chain and x are stable during EVAL.
  logic [N_IN-1:0]  w_match;
  logic [31:0]      w_pop;
  logic             w_fire;
  logic [N_OUT-1:0] w_ynext;

  always_comb begin
    w_match = ~(r_x ^ w_wt[r_k]);
    w_pop   = '0;
    for (int b = 0; b < N_IN; b++) w_pop = w_pop + 32'(w_match[b]);
    w_fire  = (w_pop >= 32'(w_th[r_k]));
  end

  // Final neuron merges with the earlier results so y updates atomically.
  always_comb begin
    w_ynext      = r_shadow;
    w_ynext[r_k] = w_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_chain  <= '0;
      r_x      <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (setup) begin
      // Setup wins over everything: shift, clear x, drop any evaluation.
      r_chain  <= {r_chain[P-2:0], param_in};
      r_x      <= '0;
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Writes land before the state decision, so a write that coincides
      // with start is seen by the evaluation.
      if (x_we && !r_busy && (int'(x_sel) < NSL))
        r_x[x_sel*CHUNK +: CHUNK] <= x_chunk;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_EVAL;
            r_k     <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_EVAL: begin
          r_shadow[r_k] <= w_fire;
          if (r_k == KW'(N_OUT-1)) begin
            r_y     <= w_ynext;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_k     <= '0;
            r_state <= S_IDLE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign param_out = r_chain[P-1];
  assign busy      = r_busy;
  assign done      = r_done;
  assign y         = r_y;

endmodule

// File: tb/tb_bnn_layer_seq.sv
module tb_bnn_layer_seq;
  localparam int N_IN  = 8;
  localparam int N_OUT = 8;
  localparam int CHUNK = 4;
  localparam int THR_W = 4;
  localparam int F     = N_IN + THR_W;
  localparam int P     = N_OUT * F;

  logic             clk = 0;
  logic             rst_n = 0;
  logic             setup = 0, param_in = 0, param_out;
  logic [CHUNK-1:0] x_chunk = '0;
  logic [0:0]       x_sel = '0;
  logic             x_we = 0, start = 0;
  logic             busy, done;
  logic [N_OUT-1:0] y;

  bnn_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK), .THR_W(THR_W)) dut (
    .clk(clk), .rst_n(rst_n), .setup(setup), .param_in(param_in),
    .param_out(param_out), .x_chunk(x_chunk), .x_sel(x_sel), .x_we(x_we),
    .start(start), .busy(busy), .done(done), .y(y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // chain_q[0] is the oldest bit (chain MSB); shifting pushes at the back.
  bit               chain_q[$];
  logic [N_IN-1:0]  m_x;
  logic [N_OUT-1:0] m_y, m_pend;
  bit               m_busy, m_done;
  int               m_left;
  logic [N_OUT-1:0] exp_q[$];

  function automatic logic [N_OUT-1:0] model_y();
    logic [N_OUT-1:0] r;
    logic [N_IN-1:0]  w;
    logic [THR_W-1:0] t;
    for (int j = 0; j < N_OUT; j++) begin
      for (int b = 0; b < N_IN; b++)  w[b] = chain_q[P-1-(j*F+b)];
      for (int b = 0; b < THR_W; b++) t[b] = chain_q[P-1-(j*F+N_IN+b)];
      r[j] = ($countones(~(m_x ^ w)) >= int'(t));
    end
    return r;
  endfunction

  task automatic model_reset();
    chain_q.delete();
    for (int i = 0; i < P; i++) chain_q.push_back(1'b0);
    m_x = '0; m_y = '0; m_busy = 0; m_done = 0; m_left = 0;
    exp_q.delete();
  endtask

  // Apply one clock edge to the model with the inputs currently driven,
  // then advance the DUT and compare the cycle-level outputs.
  task automatic step();
    m_done = 0;
    if (setup) begin
      chain_q.push_back(param_in);
      void'(chain_q.pop_front());
      m_x = '0;
      if (m_busy) begin
        m_busy = 0;
        void'(exp_q.pop_back());
      end
    end else begin
      if (x_we && !m_busy && int'(x_sel) < N_IN/CHUNK)
        m_x[int'(x_sel)*CHUNK +: CHUNK] = x_chunk;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_y = m_pend;
        end
      end else if (start) begin
        m_busy = 1; m_left = N_OUT;
        m_pend = model_y();
        exp_q.push_back(m_pend);
      end
    end
    @(posedge clk); #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("y_hold", y, m_y);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("y_result", y, exp_q.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [N_IN-1:0]  pw [N_OUT];
  logic [THR_W-1:0] pt [N_OUT];

  function automatic logic [P-1:0] pack_params();
    logic [P-1:0] v;
    v = '0;
    for (int j = 0; j < N_OUT; j++) begin
      v[j*F +: N_IN]       = pw[j];
      v[j*F+N_IN +: THR_W] = pt[j];
    end
    return v;
  endfunction

  task automatic load_params(input logic [P-1:0] v);
    for (int i = P-1; i >= 0; i--) begin
      setup = 1; param_in = v[i];
      step();
    end
    setup = 0; param_in = 0;
  endtask

  task automatic write_x(input logic [N_IN-1:0] xv);
    for (int s = 0; s < N_IN/CHUNK; s++) begin
      x_we = 1; x_sel = 1'(s); x_chunk = xv[s*CHUNK +: CHUNK];
      step();
    end
    x_we = 0;
  endtask

  task automatic run_eval();
    start = 1; step(); start = 0;
    for (int i = 0; i < 4*N_OUT && m_busy; i++) step();
    step();
  endtask

  task automatic async_rst();
    #3 rst_n = 0;
    #1;
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_param_out", param_out, 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  logic [P-1:0] vec;

  initial begin
    model_reset();
    #12;
    chk("init_y", y, 0);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_param_out", param_out, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Zero chain: every threshold 0, so all neurons fire.
    run_eval();
    chk("zero_chain_y", y, 8'hFF);

    // w=0xFF, t_j=j+1.
    for (int j = 0; j < N_OUT; j++) begin pw[j] = 8'hFF; pt[j] = 4'(j+1); end
    vec = pack_params();
    load_params(vec);
    write_x(8'h0F);
    run_eval();
    chk("pop4_y", y, 8'h0F);
    x_we = 1; x_sel = 1'b1; x_chunk = 4'h3; start = 1; step();   // write + start together
    x_we = 0; start = 0;
    for (int i = 0; i < 4*N_OUT && m_busy; i++) step();
    step();
    chk("pop6_y", y, 8'h3F);

    // Protection: writes and start during EVAL are ignored.
    start = 1; step(); start = 0;
    step();
    x_we = 1; x_sel = 1'b0; x_chunk = 4'h0; start = 1; step();
    x_we = 0; start = 0;
    for (int i = 0; i < 4*N_OUT && m_busy; i++) step();
    step(); step();
    chk("protect_y", y, 8'h3F);

    // Abort on the third EVAL edge.
    start = 1; step(); start = 0;
    step(); step();
    setup = 1; param_in = 0; step(); setup = 0;
    step();
    chk("abort_y_kept", y, 8'h3F);
    run_eval();   // x was cleared, chain shifted by one

    // Chain pass-through of the original sequence.
    load_params(vec);
    for (int i = P-1; i >= 0; i--) begin
      chk("pass_through", param_out, vec[i]);
      setup = 1; param_in = 0; step();
    end
    setup = 0;
    write_x(8'hA5);
    run_eval();
    chk("cleared_chain_y", y, 8'hFF);

    // Threshold boundaries: 9 and 15 never fire, 8 fires at full match.
    for (int j = 0; j < N_OUT; j++) begin pw[j] = 8'hFF; pt[j] = 4'($urandom_range(0, 15)); end
    pt[0] = 4'd9; pt[1] = 4'd15; pt[2] = 4'd8;
    load_params(pack_params());
    write_x(8'hFF);
    run_eval();
    chk("thr_boundary", {29'd0, y[2:0]}, 32'b100);

    // start held high re-triggers every N_OUT+1 cycles.
    start = 1;
    for (int i = 0; i < 2*(N_OUT+1); i++) step();
    start = 0;
    for (int i = 0; i < 4*N_OUT && m_busy; i++) step();
    step();

    // Asynchronous reset mid-EVAL.
    start = 1; step(); start = 0;
    step(); step();
    async_rst();
    step(); step();

    // Randomised parameters and inputs.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < N_OUT; j++) begin
        pw[j] = 8'($urandom); pt[j] = 4'($urandom_range(0, 10));
      end
      load_params(pack_params());
      for (int e = 0; e < 4; e++) begin
        write_x(8'($urandom));
        if ($urandom_range(0, 1) == 1) begin
          x_we = 1; x_sel = 1'($urandom); x_chunk = 4'($urandom);
        end
        run_eval();
        x_we = 0;
      end
    end

    step(); step();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
